// File: rtl/pipe_pkg.sv
// Shared constants for the EX->MEM pipeline stage.
//   - occupancy encodings reported on the stage's occupancy port
//   - bit positions of the commit-control fields inside the ctrl word
package pipe_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  // Control word layout. The stage treats ctrl as opaque; these indices are
  // for the producers/consumers on either side. The 3-bit condition code
  // occupies [CTRL_BR_COND +: CTRL_BR_COND_W], so carrying it needs CTRL_W >= 9.
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_JUMP       = 5;
  localparam int CTRL_BR_COND    = 6;
  localparam int CTRL_BR_COND_W  = 3;

  // Branch condition codes
  localparam logic [2:0] BR_EQ = 3'd0;
  localparam logic [2:0] BR_NE = 3'd1;
  localparam logic [2:0] BR_GT = 3'd2;
  localparam logic [2:0] BR_GE = 3'd3;
  localparam logic [2:0] BR_LT = 3'd4;
  localparam logic [2:0] BR_LE = 3'd5;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid + data + ctrl, updated on the falling clock edge.
// Ports:
//   clk, rst_n   falling-edge clock, async active-low reset
//   i_load       capture i_data/i_ctrl and set valid
//   i_clr        drop the entry: valid and ctrl cleared, data kept (wins over load)
//   o_valid/o_data/o_ctrl  registered entry
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_clr) begin
      // ctrl cleared so a dead entry never carries write enables
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline stage with valid/ready handshake, optional 2-entry skid
// buffer, flush and cache-miss freeze (hit=0). State updates on negedge clk.
// Ports:
//   clk, rst_n              falling-edge clock, async active-low reset
//   hit                     advance enable (0 = frozen; flush still acts)
//   flush                   kill held and incoming entries
//   in_valid/in_ready       upstream handshake, in_data/in_ctrl payload
//   out_valid/out_ready     downstream handshake, out_data/out_ctrl head entry
//   occupancy               entries held (0..2)
module ex_mem_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              w_in_fire, w_out_fire;
  logic              w_main_load, w_main_clr;
  logic [DATA_W-1:0] w_main_d;
  logic [CTRL_W-1:0] w_main_c;
  logic              w_main_valid;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic              w_skid_valid;

  assign w_in_fire  = in_valid & in_ready & hit & ~flush;
  assign w_out_fire = w_main_valid & out_ready & hit;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_main_load),
    .i_clr  (w_main_clr),
    .i_data (w_main_d),
    .i_ctrl (w_main_c),
    .o_valid(w_main_valid),
    .o_data (out_data),
    .o_ctrl (w_main_ctrl)
  );

  generate
    if (SKID) begin : g_skid
      logic              w_skid_load, w_skid_clr;
      logic [DATA_W-1:0] w_skid_data;
      logic [CTRL_W-1:0] w_skid_ctrl;

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_skid_load),
        .i_clr  (w_skid_clr),
        .i_data (in_data),
        .i_ctrl (in_ctrl),
        .o_valid(w_skid_valid),
        .o_data (w_skid_data),
        .o_ctrl (w_skid_ctrl)
      );

      // Ready comes straight from the skid valid flop: no path from out_ready.
      assign in_ready = ~w_skid_valid;

      // Head refills from skid when it holds an entry, otherwise from input.
      // in_fire implies the skid is empty.
      assign w_main_d    = w_skid_valid ? w_skid_data : in_data;
      assign w_main_c    = w_skid_valid ? w_skid_ctrl : in_ctrl;
      assign w_main_load = (w_in_fire & (~w_main_valid | w_out_fire))
                         | (w_skid_valid & w_out_fire);
      assign w_main_clr  = flush | (w_out_fire & ~w_main_load);
      assign w_skid_load = w_in_fire & w_main_valid & ~w_out_fire;
      assign w_skid_clr  = flush | (w_skid_valid & w_out_fire);
    end else begin : g_noskid
      assign w_skid_valid = 1'b0;
      assign in_ready     = ~w_main_valid | (out_ready & hit);
      assign w_main_d     = in_data;
      assign w_main_c     = in_ctrl;
      assign w_main_load  = w_in_fire;
      assign w_main_clr   = flush | (w_out_fire & ~w_in_fire);
    end
  endgenerate

  assign out_valid = w_main_valid;
  assign out_ctrl  = w_main_ctrl & {CTRL_W{w_main_valid}};
  assign occupancy = w_skid_valid ? OCC_FULL : (w_main_valid ? OCC_ONE : OCC_EMPTY);

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
module tb_ex_mem_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n, hit, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_data, b_out_data;
  logic [7:0]  a_out_ctrl, b_out_ctrl;
  logic [1:0]  a_occ, b_occ;

  int n_chk = 0;
  int n_fail = 0;

  // reference queues of {data, ctrl}; a = skid build (cap 2), b = single entry
  logic [39:0] qa[$];
  logic [39:0] qb[$];

  always #5 clk = ~clk;

  ex_mem_skid_stage #(.DATA_W(32), .CTRL_W(8), .SKID(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .hit(hit), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .occupancy(a_occ)
  );

  ex_mem_skid_stage #(.DATA_W(32), .CTRL_W(8), .SKID(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .hit(hit), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .occupancy(b_occ)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [39:0] h;
    chk("a_valid", a_out_valid, qa.size() > 0);
    chk("a_occ", a_occ, qa.size());
    chk("a_ready", a_in_ready, qa.size() < 2);
    if (qa.size() > 0) begin
      h = qa[0];
      chk("a_data", a_out_data, h[39:8]);
      chk("a_ctrl", a_out_ctrl, h[7:0]);
    end else chk("a_ctrl_idle", a_out_ctrl, 0);
    chk("b_valid", b_out_valid, qb.size() > 0);
    chk("b_occ", b_occ, qb.size());
    chk("b_ready", b_in_ready, (qb.size() == 0) || (out_ready && hit));
    if (qb.size() > 0) begin
      h = qb[0];
      chk("b_data", b_out_data, h[39:8]);
      chk("b_ctrl", b_out_ctrl, h[7:0]);
    end else chk("b_ctrl_idle", b_out_ctrl, 0);
  endtask

  // Apply inputs, check against the model, advance one falling edge.
  task automatic step(input logic h, input logic f, input logic iv,
                      input logic [31:0] d, input logic [7:0] c, input logic orr);
    bit ra, rb, va, vb;
    hit = h; flush = f; in_valid = iv; in_data = d; in_ctrl = c; out_ready = orr;
    #1;
    check_model();
    @(negedge clk);
    ra = qa.size() < 2;
    rb = (qb.size() == 0) || (orr && h);
    va = qa.size() > 0;
    vb = qb.size() > 0;
    if (va && orr && h) void'(qa.pop_front());
    if (vb && orr && h) void'(qb.pop_front());
    if (f) begin
      qa.delete();
      qb.delete();
    end else begin
      if (iv && ra && h) qa.push_back({d, c});
      if (iv && rb && h) qb.push_back({d, c});
    end
    @(posedge clk);
  endtask

  typedef struct {
    logic        hit, flush, iv;
    logic [31:0] d;
    logic [7:0]  c;
    logic        orr;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  eocc;
    logic        erdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [31:0] d, logic orr,
                              logic ev, logic [31:0] ed, logic [1:0] eocc, logic erdy);
    vec_t v;
    v.hit = 1'b1; v.flush = 1'b0; v.iv = iv; v.d = d; v.c = d[7:0]; v.orr = orr;
    v.ev = ev; v.ed = ed; v.eocc = eocc; v.erdy = erdy;
    return v;
  endfunction

  initial begin
    // streaming 1..8, one-edge latency, occupancy stays 1
    for (int i = 1; i <= 8; i++) tbl.push_back(mk(1, i, 1, 1, i, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1));
    // backpressure: A, B fill the stage, C is held upstream until room
    tbl.push_back(mk(1, 32'hA, 0, 1, 32'hA, 1, 1));
    tbl.push_back(mk(1, 32'hB, 0, 1, 32'hA, 2, 0));
    tbl.push_back(mk(1, 32'hC, 0, 1, 32'hA, 2, 0));
    tbl.push_back(mk(1, 32'hC, 1, 1, 32'hB, 1, 1));
    tbl.push_back(mk(1, 32'hC, 1, 1, 32'hC, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1));

    rst_n = 1'b0; hit = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    #1;
    chk("rst_a_occ", a_occ, 0);
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_ready", a_in_ready, 1);
    chk("rst_b_ready", b_in_ready, 1);
    @(posedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].hit, tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].orr);
      #1;
      chk($sformatf("tbl%0d_valid", i), a_out_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), a_out_data, tbl[i].ed);
      chk($sformatf("tbl%0d_occ", i), a_occ, tbl[i].eocc);
      chk($sformatf("tbl%0d_ready", i), a_in_ready, tbl[i].erdy);
    end

    // freeze with a full stage and a waiting input
    step(1, 0, 1, 32'h11, 8'h11, 0);
    step(1, 0, 1, 32'h22, 8'h22, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 32'h33, 8'h33, 1);
      #1;
      chk("frz_occ", a_occ, 2);
      chk("frz_data", a_out_data, 32'h11);
      chk("frz_ready", a_in_ready, 0);
    end
    step(1, 0, 1, 32'h33, 8'h33, 1);
    #1; chk("frz_res1", a_out_data, 32'h22);
    step(1, 0, 1, 32'h33, 8'h33, 1);
    #1; chk("frz_res2", a_out_data, 32'h33);
    step(1, 0, 0, 0, 0, 1);
    #1; chk("frz_drain", a_occ, 0);

    // flush while frozen, two ctrl=FF entries held plus one incoming
    step(1, 0, 1, 32'h44, 8'hFF, 0);
    step(1, 0, 1, 32'h55, 8'hFF, 0);
    #1; chk("fl_pre_occ", a_occ, 2);
    step(0, 1, 1, 32'h66, 8'hFF, 0);
    #1;
    chk("fl_occ", a_occ, 0);
    chk("fl_ctrl", a_out_ctrl, 0);
    chk("fl_valid", a_out_valid, 0);
    chk("fl_b_ctrl", b_out_ctrl, 0);
    step(1, 0, 0, 0, 0, 1);
    #1; chk("fl_no_ghost", a_out_valid, 0);

    // async reset in the middle of a full stage, between clock edges
    step(1, 0, 1, 32'h77, 8'h5A, 0);
    step(1, 0, 1, 32'h88, 8'hA5, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_occ", a_occ, 0);
    chk("mrst_valid", a_out_valid, 0);
    chk("mrst_ctrl", a_out_ctrl, 0);
    chk("mrst_ready", a_in_ready, 1);
    chk("mrst_b_valid", b_out_valid, 0);
    qa.delete();
    qb.delete();
    @(posedge clk);
    rst_n = 1'b1;

    // single-entry build with out_ready toggling
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 1, 32'h100 + k, k[7:0], (k % 2) == 0);
      #1; chk("b_occ_max", b_occ <= 2'd1, 1);
    end
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 1);

    // randomized traffic against the queue model
    for (int k = 0; k < 800; k++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) != 0, $urandom, 8'($urandom),
           $urandom_range(0, 2) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
